// File: rtl/idct_vecrot_frame_ctrl.sv
// Frame sequencer feeding idct_vecRot from a dual-read frame RAM (k and N-k reads).
// Optional frame/stall counters are enabled with `define IDCT_CTRL_FRMCNT_EN.
module idct_vecrot_frame_ctrl #(
    parameter int wData      = 24,
    parameter int wAddr      = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frm_avail,
    input  logic [11:0]        fftpts_in,
    output logic               frm_release,
    output logic               rd_en,
    output logic [wAddr-1:0]   rd_addr,
    output logic [wAddr-1:0]   rd_addr_rev,
    input  logic [2*wData-1:0] rd_data,
    input  logic [2*wData-1:0] rd_data_rev,
    output logic               source_valid,
    input  logic               source_ready,
    output logic               source_sop,
    output logic               source_eop,
    output logic [wData-1:0]   source_real,
    output logic [wData-1:0]   source_imag,
    output logic [wData-1:0]   source_real_rev,
    output logic [wData-1:0]   source_imag_rev,
    output logic [11:0]        fftpts_out,
    output logic               busy,
    output logic               cfg_err
`ifdef IDCT_CTRL_FRMCNT_EN
    ,
    output logic [15:0]        frm_cnt,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 4 * wData + 2;
    localparam logic [31:0] NMAX = 32'(1) << wAddr;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [wAddr-1:0] k_q, k_d;
    logic [wAddr-1:0] addr_q, addr_d;
    logic [wAddr-1:0] raddr_q, raddr_d;
    logic [wAddr-1:0] n_m1;
    logic [11:0]      n_q, n_d;
    logic             err_q, err_d;
    logic             rel_q, rel_d;
    logic             rd_en_q, rd_en_d;
    logic             tsop_q, tsop_d, teop_q, teop_d;
    logic             infl_q, infl_d;
    logic             isop_q, isop_d, ieop_q, ieop_d;
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [EW-1:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [EW-1:0]    head;
    logic             legal, credit, push, pop, last_pop;

    assign n_m1   = wAddr'(n_q - 12'd1);
    assign legal  = (fftpts_in >= 12'd8)
                 && ((fftpts_in & (fftpts_in - 12'd1)) == 12'd0)
                 && (32'(fftpts_in) <= NMAX);
    // Reads in the RAM pipeline count against FIFO space so a push never overflows.
    assign credit = (int'(cnt_q) + int'(rd_en_q) + int'(infl_q)) < FIFO_DEPTH;
    assign head     = mem_q[rp_q];
    assign push     = infl_q;
    assign pop      = (cnt_q != '0) && source_ready;
    assign last_pop = pop && head[0];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        err_d   = err_q;
        rel_d   = 1'b0;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        raddr_d = raddr_q;
        tsop_d  = tsop_q;
        teop_d  = teop_q;
        unique case (state_q)
            IDLE: begin
                if (frm_avail) begin
                    n_d = fftpts_in;
                    if (legal) begin
                        err_d   = 1'b0;
                        k_d     = '0;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                        rel_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (credit) begin
                    rd_en_d = 1'b1;
                    addr_d  = k_q;
                    raddr_d = (wAddr'(0) - k_q) & n_m1;
                    tsop_d  = (k_q == '0);
                    teop_d  = (k_q == n_m1);
                    k_d     = k_q + wAddr'(1);
                    if (k_q == n_m1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    rel_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        infl_d = rd_en_q;
        isop_d = tsop_q;
        ieop_d = teop_q;
        mem_d  = mem_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        if (push) begin
            mem_d[wp_q] = {rd_data, rd_data_rev, isop_q, ieop_q};
            wp_d        = wp_q + PW'(1);
        end
        if (pop) rp_d = rp_q + PW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            err_q   <= 1'b0;
            rel_q   <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            raddr_q <= '0;
            tsop_q  <= 1'b0;
            teop_q  <= 1'b0;
            infl_q  <= 1'b0;
            isop_q  <= 1'b0;
            ieop_q  <= 1'b0;
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            err_q   <= err_d;
            rel_q   <= rel_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            raddr_q <= raddr_d;
            tsop_q  <= tsop_d;
            teop_q  <= teop_d;
            infl_q  <= infl_d;
            isop_q  <= isop_d;
            ieop_q  <= ieop_d;
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign frm_release     = rel_q;
    assign rd_en           = rd_en_q;
    assign rd_addr         = addr_q;
    assign rd_addr_rev     = raddr_q;
    assign source_valid    = (cnt_q != '0);
    assign source_real     = head[EW-1 -: wData];
    assign source_imag     = head[EW-1-wData -: wData];
    assign source_real_rev = head[2*wData+1 -: wData];
    assign source_imag_rev = head[wData+1 -: wData];
    assign source_sop      = head[1];
    assign source_eop      = head[0];
    assign fftpts_out      = n_q;
    assign busy            = (state_q != IDLE);
    assign cfg_err         = err_q;

`ifdef IDCT_CTRL_FRMCNT_EN
    logic [15:0] frm_cnt_q, frm_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        frm_cnt_d   = frm_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == DRAIN) && last_pop && (frm_cnt_q != 16'hFFFF))
            frm_cnt_d = frm_cnt_q + 16'd1;
        if (source_valid && !source_ready && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            frm_cnt_q   <= frm_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign frm_cnt   = frm_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_idct_vecrot_frame_ctrl.sv
// Bench for idct_vecrot_frame_ctrl: frame table plus hand-written corner sequences.
// Counter checks run only when IDCT_CTRL_FRMCNT_EN is defined.
module tb_idct_vecrot_frame_ctrl;

    localparam int WD = 24;
    localparam int WA = 11;
    localparam logic [23:0] IMX = 24'hABC000;

    typedef struct packed {
        logic [23:0] re;
        logic [23:0] im;
        logic [23:0] rre;
        logic [23:0] rim;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct {
        int n;
        int mode;
        int exp_err;
        int exp_cyc;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frm_avail = 1'b0;
    logic [11:0]   fftpts_in = '0;
    logic          frm_release;
    logic          rd_en;
    logic [WA-1:0] rd_addr, rd_addr_rev;
    logic [47:0]   rd_data = '0;
    logic [47:0]   rd_data_rev = '0;
    logic          source_valid;
    logic          source_ready = 1'b1;
    logic          source_sop, source_eop;
    logic [WD-1:0] source_real, source_imag;
    logic [WD-1:0] source_real_rev, source_imag_rev;
    logic [11:0]   fftpts_out;
    logic          busy, cfg_err;
`ifdef IDCT_CTRL_FRMCNT_EN
    logic [15:0]   frm_cnt, stall_cnt;
`endif

    int    n_cmp = 0;
    int    n_bad = 0;
    int    issued = 0;
    int    popped = 0;
    int    rel_cnt = 0;
    int    valid_cnt = 0;
    int    stall_left = 0;
    beat_t sb[$];
    int    addr_log[$];
    int    rev_log[$];
    vec_t  tbl[9];
    logic  any_out;

    idct_vecrot_frame_ctrl #(.wData(WD), .wAddr(WA), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .frm_avail(frm_avail), .fftpts_in(fftpts_in),
        .frm_release(frm_release),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_addr_rev(rd_addr_rev),
        .rd_data(rd_data), .rd_data_rev(rd_data_rev),
        .source_valid(source_valid), .source_ready(source_ready),
        .source_sop(source_sop), .source_eop(source_eop),
        .source_real(source_real), .source_imag(source_imag),
        .source_real_rev(source_real_rev), .source_imag_rev(source_imag_rev),
        .fftpts_out(fftpts_out), .busy(busy), .cfg_err(cfg_err)
`ifdef IDCT_CTRL_FRMCNT_EN
        , .frm_cnt(frm_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign any_out = |{frm_release, rd_en, rd_addr, rd_addr_rev, source_valid,
                       source_sop, source_eop, source_real, source_imag,
                       source_real_rev, source_imag_rev, fftpts_out, busy, cfg_err};

    // Frame RAM: word at address a is {a, a^IMX}; one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data     <= {24'(rd_addr), 24'(rd_addr) ^ IMX};
            rd_data_rev <= {24'(rd_addr_rev), 24'(rd_addr_rev) ^ IMX};
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            issued = 0;
            popped = 0;
        end else begin
            if (rd_en) begin
                issued++;
                addr_log.push_back(int'(rd_addr));
                rev_log.push_back(int'(rd_addr_rev));
                check("credit_bound", 64'((issued - popped) <= 4), 64'(1));
            end
            if (source_valid) valid_cnt++;
            if (frm_release) rel_cnt++;
            if (source_valid && source_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    beat_t e;
                    e = sb.pop_front();
                    check("beat_fwd", {source_real, source_imag}, {e.re, e.im});
                    check("beat_rev", {source_real_rev, source_imag_rev}, {e.rre, e.rim});
                    check("beat_tags", {source_sop, source_eop}, {e.sop, e.eop});
                end
                popped++;
            end
        end
    end

    task automatic push_frame(input int n);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            int r;
            r     = (n - k) & (n - 1);
            b.re  = 24'(k);
            b.im  = 24'(k) ^ IMX;
            b.rre = 24'(r);
            b.rim = 24'(r) ^ IMX;
            b.sop = (k == 0);
            b.eop = (k == n - 1);
            sb.push_back(b);
        end
    endtask

    task automatic drive_ready(input int mode);
        case (mode)
            1: source_ready = !source_ready;
            2: source_ready = ($urandom_range(0, 9) >= 3);
            3: begin
                if (source_valid && stall_left > 0) begin
                    source_ready = 1'b0;
                    stall_left--;
                end else begin
                    source_ready = 1'b1;
                end
            end
            default: source_ready = 1'b1;
        endcase
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("rst_outs_zero", 64'(any_out), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic run_frame(input int n, input int mode, input int exp_err, input int exp_cyc);
        int rel0, iss0, val0, rel_cyc, budget;
        budget = 4 * n + 64;
        rel0 = rel_cnt;
        iss0 = issued;
        val0 = valid_cnt;
        rel_cyc = 0;
        addr_log.delete();
        rev_log.delete();
        if (exp_err == 0) push_frame(n);
        @(posedge clk);
        #1;
        fftpts_in = 12'(n);
        frm_avail = 1'b1;
        drive_ready(mode);
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            frm_avail = 1'b0;
            drive_ready(mode);
            if (busy) check("fftpts_run", 64'(fftpts_out), 64'(n));
            if (frm_release) begin
                rel_cyc = c;
                break;
            end
        end
        check("release_seen", 64'(rel_cyc != 0), 64'(1));
        if (exp_cyc != 0) check("release_cycle", 64'(rel_cyc), 64'(exp_cyc));
        repeat (3) begin
            @(posedge clk);
            #1 drive_ready(mode);
        end
        check("release_once", 64'(rel_cnt - rel0), 64'(1));
        check("cfg_err", 64'(cfg_err), 64'(exp_err));
        check("fftpts_latched", 64'(fftpts_out), 64'(n & 12'hFFF));
        check("busy_after", 64'(busy), 64'(0));
        if (exp_err == 0) begin
            check("beats_left", 64'(sb.size()), 64'(0));
            check("read_count", 64'(issued - iss0), 64'(n));
            for (int i = 0; i < addr_log.size(); i++) begin
                check("rd_addr", 64'(addr_log[i]), 64'(i));
                check("rd_addr_rev", 64'(rev_log[i]), 64'((n - i) & (n - 1)));
            end
        end else begin
            check("no_reads", 64'(issued - iss0), 64'(0));
            check("no_valid", 64'(valid_cnt - val0), 64'(0));
        end
        sb.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r1, r2, p0, rel0;
        bit hit;
        tbl[0] = '{n: 8,    mode: 0, exp_err: 0, exp_cyc: 12};
        tbl[1] = '{n: 16,   mode: 1, exp_err: 0, exp_cyc: 0};
        tbl[2] = '{n: 16,   mode: 2, exp_err: 0, exp_cyc: 0};
        tbl[3] = '{n: 12,   mode: 0, exp_err: 1, exp_cyc: 1};
        tbl[4] = '{n: 4,    mode: 0, exp_err: 1, exp_cyc: 1};
        tbl[5] = '{n: 32,   mode: 0, exp_err: 0, exp_cyc: 36};
        tbl[6] = '{n: 0,    mode: 0, exp_err: 1, exp_cyc: 1};
        tbl[7] = '{n: 2048, mode: 0, exp_err: 0, exp_cyc: 2052};
        tbl[8] = '{n: 3000, mode: 0, exp_err: 1, exp_cyc: 1};

        do_reset();
        for (int i = 0; i < 9; i++)
            run_frame(tbl[i].n, tbl[i].mode, tbl[i].exp_err, tbl[i].exp_cyc);

        // Back-to-back frames with frm_avail held high.
        r1 = 0;
        r2 = 0;
        rel0 = rel_cnt;
        push_frame(8);
        push_frame(8);
        @(posedge clk);
        #1;
        fftpts_in = 12'd8;
        frm_avail = 1'b1;
        source_ready = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (frm_release) begin
                if (r1 == 0) begin
                    r1 = c;
                end else begin
                    r2 = c;
                    frm_avail = 1'b0;
                    break;
                end
            end
        end
        frm_avail = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("b2b_rel1", 64'(r1), 64'(12));
        check("b2b_rel2", 64'(r2), 64'(24));
        check("b2b_rel_total", 64'(rel_cnt - rel0), 64'(2));
        check("b2b_beats_left", 64'(sb.size()), 64'(0));
        sb.delete();

        // Reset while beat 5 of an N=64 frame is presented.
        p0 = popped;
        hit = 1'b0;
        push_frame(64);
        @(posedge clk);
        #1;
        fftpts_in = 12'd64;
        frm_avail = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            frm_avail = 1'b0;
            if (popped - p0 == 5) begin
                hit = 1'b1;
                break;
            end
        end
        check("abort_reached_beat5", 64'(hit), 64'(1));
        check("abort_beat5_valid", {source_valid, source_real}, {1'b1, 24'd5});
        rel0 = rel_cnt;
        rst = 1'b1;
        #1 check("abort_outs_zero", 64'(any_out), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_release", 64'(rel_cnt - rel0), 64'(0));
        check("abort_idle", 64'(busy), 64'(0));
        run_frame(8, 0, 0, 12);

`ifdef IDCT_CTRL_FRMCNT_EN
        do_reset();
        check("frm_cnt_rst", 64'(frm_cnt), 64'(0));
        check("stall_cnt_rst", 64'(stall_cnt), 64'(0));
        stall_left = 10;
        run_frame(8, 3, 0, 0);
        run_frame(12, 0, 1, 1);
        run_frame(8, 0, 0, 12);
        run_frame(16, 0, 0, 20);
        check("frm_cnt", 64'(frm_cnt), 64'(3));
        check("stall_cnt", 64'(stall_cnt), 64'(10));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/idct_vecrot_frame_ctrl.md
Name: idct_vecrot_frame_ctrl

Overview:
Frame sequencer that feeds idct_vecRot from an external dual-read frame RAM holding one frame of DCT coefficients D1.
- For each frame it issues paired reads: k and (N-k) mod N. This produces the forward and reversed operands (sink_real/imag and sink_real_rev/imag_rev) in one beat.
- Absorbs RAM read latency and downstream backpressure with an internal skid FIFO.
- Generates sop/eop and carries fftpts.
- Returns the frame buffer to the writer once the last sample is accepted.

Parameters:
wData, 24, width of each real/imag component
wAddr, 11, RAM address width; max N = 2^wAddr
FIFO_DEPTH, 4, skid FIFO entries (power of 2, >= 4)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
frm_avail  in  1  frame RAM holds a complete frame (level)
fftpts_in  in  12  N for the pending frame; sampled at frame start
frm_release  out  1  one-cycle pulse: frame consumed, RAM may be rewritten
rd_en  out  1  RAM read strobe; data returns exactly 1 cycle later
rd_addr  out  wAddr  forward address k
rd_addr_rev  out  wAddr  reverse address (N-k)&(N-1)
rd_data  in  2*wData  {real,imag} at rd_addr
rd_data_rev  in  2*wData  {real,imag} at rd_addr_rev
source_valid  out  1  to idct_vecRot sink_valid
source_ready  in  1  from idct_vecRot sink_ready
source_sop  out  1  first sample (k=0)
source_eop  out  1  last sample (k=N-1)
source_real, source_imag, source_real_rev, source_imag_rev  out  wData each  operands
fftpts_out  out  12  latched N, stable for the whole frame
busy  out  1  state != IDLE
cfg_err  out  1  sticky: last frame had illegal N

Behaviour:
- Reset (async, immediate): state=IDLE, all outputs 0, FIFO empty, k=0, in-flight flag 0. Reset mid-frame aborts silently; no frm_release is issued.
- States: IDLE, RUN, DRAIN.
- IDLE, frm_avail=1 at an edge: latch N=fftpts_in into fftpts_out.
  - Legal N = power of 2, 8 <= N <= 2^wAddr. If legal: set cfg_err=0, go to RUN with k=0.
  - If illegal: set cfg_err=1, pulse frm_release next cycle, stay IDLE. No reads, no output.
- RUN, read issue: rd_en=1 when (FIFO occupancy + in-flight) < FIFO_DEPTH. The issued read carries rd_addr=k, rd_addr_rev=(N-k)&(N-1), so k=0 gives rev address 0.
- RUN, advance: k increments on each issued read. The read with k=N-1 moves the state to DRAIN.
- Read return: rd_data and rd_data_rev are pushed into the FIFO the cycle after rd_en, tagged sop=(k==0) and eop=(k==N-1).
- Output side: source_* come from the FIFO head, registered.
  - source_valid=1 whenever the FIFO is non-empty.
  - A pop occurs when source_valid & source_ready.
  - Data, sop and eop hold stable while valid & !ready.
- FIFO overflow is impossible by the credit rule. The bench asserts this.
- DRAIN: no reads. On a pop with eop=1, pulse frm_release for 1 cycle and go to IDLE.
  - A new frame may start at the earliest on the cycle after that pulse, since frm_avail is resampled in IDLE.
- Latency and throughput:
  - First rd_en occurs the cycle after entering RUN.
  - First source_valid occurs 2 cycles after the first rd_en.
  - With source_ready=1, one sample per cycle sustained, so a frame takes N+4 cycles from frm_avail to frm_release.
- Simultaneous push and pop in one cycle: occupancy unchanged. A push into an empty FIFO with source_ready=1 is still registered first (no bypass).
- Changes on fftpts_in or frm_avail during RUN/DRAIN are ignored.

Optional Feature:
IDCT_CTRL_FRMCNT_EN
- Defined: adds outputs frm_cnt (16-bit) and stall_cnt (16-bit). Both reset to 0 and saturate at 0xFFFF.
  - frm_cnt increments on each frm_release of a legal frame.
  - stall_cnt increments each cycle with source_valid & !source_ready.
- Not defined: ports absent, no extra logic.

Test Plan:
- N=8, source_ready=1, RAM word = address, frm_avail=1:
  - rd_addr 0..7, rd_addr_rev 0,7,6,5,4,3,2,1.
  - 8 beats, sop on beat 0, eop on beat 7.
  - frm_release at cycle 12 after frm_avail. fftpts_out=8 throughout.
- N=16, source_ready toggled 1-0-1-0 or random 30% low: output sequence identical to the no-stall case, no sample lost or duplicated, occupancy+in-flight never exceeds 4.
- fftpts_in=12, then fftpts_in=4: each sets cfg_err=1, issues no rd_en and no source_valid, pulses frm_release once; the next legal N=32 clears cfg_err.
- Back-to-back N=8 frames with frm_avail held high: second sop follows first eop, separated by the release cycle plus pipeline refill; both frames complete.
- Assert rst during beat 5 of an N=64 frame: all outputs 0 immediately, no frm_release; the following N=8 frame runs cleanly.
- With IDCT_CTRL_FRMCNT_EN: 3 legal frames plus 1 illegal frame give frm_cnt=3; 10 forced stall cycles give stall_cnt=10.
